// File: rtl/vmem_pkg.sv
// Shared types and sizing helpers for the vector data memory slice.
package vmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDWAIT,
        ERR,
        DONE
    } state_t;

    localparam int DEF_LANES      = 32;
    localparam int DEF_LANE_W     = 8;
    localparam int DEF_BEAT_LANES = 8;
    localparam int DEF_DEPTH      = 1024;
    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_VEC_W      = DEF_LANES * DEF_LANE_W;
    localparam int DEF_BEAT_W     = DEF_BEAT_LANES * DEF_LANE_W;

    // Number of bank beats needed to move one full vector.
    function automatic int beats(input int lanes, input int beat_lanes);
        return lanes / beat_lanes;
    endfunction

    // Address width of the narrow bank holding depth*nbeats words.
    function automatic int bank_addr_w(input int depth, input int nbeats);
        return (depth * nbeats > 1) ? $clog2(depth * nbeats) : 1;
    endfunction

endpackage

// File: rtl/vmem_bank.sv
// Single-port synchronous RAM with per-lane write enables and one-cycle read latency.
module vmem_bank #(
    parameter int WORDS  = 4096,
    parameter int AW     = 12,
    parameter int LANES  = 8,
    parameter int LANE_W = 8
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [AW-1:0]             addr,
    input  logic [LANES*LANE_W-1:0]   wdata,
    input  logic [LANES-1:0]          wmask,
    output logic [LANES*LANE_W-1:0]   rdata
);

    logic [LANES*LANE_W-1:0] mem [WORDS];

    // Read-first port: lanes with their enable set are written, the old word is returned.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (wmask[i]) begin
                        mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                    end
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/vector_data_memory.sv
// Vector data memory: each vector access is split into BEATS accesses of a narrow bank.
module vector_data_memory
    import vmem_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int LANE_W     = DEF_LANE_W,
    parameter int BEAT_LANES = DEF_BEAT_LANES,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [LANES*LANE_W-1:0]  req_wdata,
    input  logic [LANES-1:0]         req_mask,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [LANES*LANE_W-1:0]  resp_rdata,
    output logic                     resp_err
);

    localparam int VEC_W      = LANES * LANE_W;
    localparam int BEATS      = beats(LANES, BEAT_LANES);
    localparam int BEAT_W     = BEAT_LANES * LANE_W;
    localparam int BANK_WORDS = DEPTH * BEATS;
    localparam int BANK_AW    = bank_addr_w(DEPTH, BEATS);
    localparam int BEAT_CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t               state;
    state_t               next_state;
    logic [ADDR_W-1:0]    addr_q;
    logic [VEC_W-1:0]     wdata_q;
    logic [LANES-1:0]     mask_q;
    logic [BEAT_CW-1:0]   beat;
    logic                 cap_en;
    logic [BEAT_CW-1:0]   cap_idx;
    logic                 accept;
    logic                 out_of_range;
    logic                 beat_last;
    logic                 bank_en;
    logic                 bank_we;
    logic [BANK_AW-1:0]   bank_addr;
    logic [BEAT_W-1:0]    bank_wdata;
    logic [BEAT_W-1:0]    bank_rdata;
    logic [BEAT_LANES-1:0] bank_wmask;

    assign req_ready    = (state == IDLE);
    assign accept       = req_valid && req_ready;
    assign out_of_range = ({1'b0, req_addr} >= DEPTH_LIM);
    assign beat_last    = (beat == BEAT_CW'(BEATS - 1));
    assign bank_addr    = BANK_AW'(addr_q) * BANK_AW'(BEATS) + BANK_AW'(beat);
    assign bank_wdata   = wdata_q[beat*BEAT_W +: BEAT_W];
    assign bank_wmask   = mask_q[beat*BEAT_LANES +: BEAT_LANES];

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection and bank strobes for the current beat.
    always_comb begin
        next_state = state;
        bank_en    = 1'b0;
        bank_we    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (out_of_range) begin
                        next_state = ERR;
                    end else if (req_write) begin
                        next_state = WR;
                    end else begin
                        next_state = RD;
                    end
                end
            end
            WR: begin
                bank_en = 1'b1;
                bank_we = 1'b1;
                if (beat_last) begin
                    next_state = DONE;
                end
            end
            RD: begin
                bank_en = 1'b1;
                if (beat_last) begin
                    next_state = RDWAIT;
                end
            end
            RDWAIT: begin
                next_state = DONE;
            end
            ERR: begin
                next_state = DONE;
            end
            DONE: begin
                if (resp_valid && resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, beat sequencing, read assembly and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            beat       <= '0;
            cap_en     <= 1'b0;
            cap_idx    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            cap_en  <= (state == RD);
            cap_idx <= beat;
            if (cap_en) begin
                resp_rdata[cap_idx*BEAT_W +: BEAT_W] <= bank_rdata;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        mask_q     <= req_mask;
                        beat       <= '0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
                WR, RD: begin
                    if (!beat_last) begin
                        beat <= beat + 1'b1;
                    end
                end
                ERR: begin
                    resp_err   <= 1'b1;
                    resp_rdata <= '0;
                end
                DONE: begin
                    if (!resp_valid) begin
                        resp_valid <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    vmem_bank #(
        .WORDS  (BANK_WORDS),
        .AW     (BANK_AW),
        .LANES  (BEAT_LANES),
        .LANE_W (LANE_W)
    ) bank (
        .clk   (clk),
        .en    (bank_en),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .wmask (bank_wmask),
        .rdata (bank_rdata)
    );

endmodule

// File: tb/tb_vector_data_memory.sv
// Scoreboard bench for vector_data_memory: directed cases followed by a random soak.
module tb_vector_data_memory;

    localparam int LANES  = 32;
    localparam int LANE_W = 8;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 15;
    localparam int VEC_W  = LANES * LANE_W;

    typedef struct {
        logic [VEC_W-1:0] rdata;
        logic             err;
        int               latency;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [ADDR_W-1:0]  req_addr;
    logic [VEC_W-1:0]   req_wdata;
    logic [LANES-1:0]   req_mask;
    logic               resp_valid;
    logic               resp_ready;
    logic [VEC_W-1:0]   resp_rdata;
    logic               resp_err;

    exp_t             sbq[$];
    logic [VEC_W-1:0] model [DEPTH];
    int               checks = 0;
    int               errors = 0;

    vector_data_memory dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_mask   (req_mask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the design wedges somewhere the bounded waits do not cover.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [VEC_W-1:0] observed,
                               input logic [VEC_W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [VEC_W-1:0] randVec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    // Drive one request at a falling edge, hold it through the accept edge, record the expectation.
    task automatic applyStimulus(input logic write, input logic [ADDR_W-1:0] addr,
                                 input logic [VEC_W-1:0] wdata, input logic [LANES-1:0] mask);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", VEC_W'(req_ready), VEC_W'(1));
        req_valid = 1'b1;
        req_write = write;
        req_addr  = addr;
        req_wdata = wdata;
        req_mask  = mask;
        @(posedge clk);
        e.err     = (int'(addr) >= DEPTH);
        e.latency = e.err ? 2 : (write ? 5 : 6);
        e.rdata   = '0;
        if (!e.err) begin
            if (write) begin
                for (int i = 0; i < LANES; i++) begin
                    if (mask[i]) model[addr][i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
                end
            end else begin
                e.rdata = model[addr];
            end
        end
        sbq.push_back(e);
    endtask

    // Wait for the response, check it, hold it for 'hold' cycles, then consume it.
    task automatic waitResponse(input int hold, input bit pressValid);
        exp_t e;
        int   n;
        bit   seen;
        bit   bankHit;
        n       = 0;
        seen    = 1'b0;
        bankHit = 1'b0;
        while (!seen && n <= 20) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_addr  = ADDR_W'($urandom);
            req_wdata = randVec();
            req_mask  = LANES'($urandom);
            if (dut.bank_en) bankHit = 1'b1;
            if (resp_valid) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                n++;
            end
        end
        e = sbq.pop_front();
        if (!seen) checkOutput("resp_valid_timeout", VEC_W'(resp_valid), VEC_W'(1));
        checkOutput("latency", VEC_W'(n), VEC_W'(e.latency));
        checkOutput("rdata", resp_rdata, e.rdata);
        checkOutput("err", VEC_W'(resp_err), VEC_W'(e.err));
        if (e.err) checkOutput("bank_idle_on_err", VEC_W'(bankHit), VEC_W'(0));
        if (pressValid) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = ADDR_W'(3);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", VEC_W'(resp_valid), VEC_W'(1));
            checkOutput("hold_rdata", resp_rdata, e.rdata);
            checkOutput("hold_err", VEC_W'(resp_err), VEC_W'(e.err));
            checkOutput("hold_req_ready", VEC_W'(req_ready), VEC_W'(0));
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        checkOutput("post_valid", VEC_W'(resp_valid), VEC_W'(0));
        checkOutput("post_err", VEC_W'(resp_err), VEC_W'(0));
        checkOutput("post_req_ready", VEC_W'(req_ready), VEC_W'(1));
    endtask

    task automatic runTransaction(input logic write, input logic [ADDR_W-1:0] addr,
                                  input logic [VEC_W-1:0] wdata, input logic [LANES-1:0] mask,
                                  input int hold, input bit pressValid);
        applyStimulus(write, addr, wdata, mask);
        waitResponse(hold, pressValid);
    endtask

    initial begin
        logic [VEC_W-1:0]  v;
        logic [VEC_W-1:0]  aa;
        logic [ADDR_W-1:0] a;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_mask   = '0;
        resp_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset_req_ready", VEC_W'(req_ready), VEC_W'(1));
        checkOutput("reset_resp_valid", VEC_W'(resp_valid), VEC_W'(0));
        checkOutput("reset_resp_err", VEC_W'(resp_err), VEC_W'(0));
        checkOutput("reset_resp_rdata", resp_rdata, '0);
        rst = 1'b0;

        // Lane-index write and read back at address 5
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = 8'(i);
        runTransaction(1'b1, 15'd5, v, '1, 0, 1'b0);
        runTransaction(1'b0, 15'd5, '0, '0, 0, 1'b0);
        checkOutput("lane_index_pattern", model[5], v);

        // Masked write: lower 16 lanes overwritten, upper 16 keep their index values
        runTransaction(1'b1, 15'd5, {32{8'hFF}}, 32'h0000FFFF, 0, 1'b0);
        runTransaction(1'b0, 15'd5, '0, '0, 1, 1'b0);

        // Fill the rest of the memory so every later read has known contents
        for (int i = 0; i < DEPTH; i++) begin
            if (i != 5) runTransaction(1'b1, ADDR_W'(i), randVec(), '1, 0, 1'b0);
        end

        // Top address, bottom address and aliasing between them
        runTransaction(1'b1, 15'd1023, randVec(), '1, 0, 1'b0);
        runTransaction(1'b1, 15'd0, randVec(), '1, 0, 1'b0);
        runTransaction(1'b0, 15'd1023, '0, '0, 0, 1'b0);
        runTransaction(1'b0, 15'd0, '0, '0, 0, 1'b0);
        runTransaction(1'b0, 15'd1024, '0, '0, 0, 1'b0);
        runTransaction(1'b1, 15'd32767, randVec(), '1, 2, 1'b0);

        // Back-pressure with a second request waiting
        runTransaction(1'b0, 15'd5, '0, '0, 10, 1'b1);

        // All-zero mask still runs the full write and changes nothing
        runTransaction(1'b1, 15'd9, randVec(), '0, 0, 1'b0);
        runTransaction(1'b0, 15'd9, '0, '0, 0, 1'b0);

        // Reset during the third write beat
        runTransaction(1'b1, 15'd7, '0, '1, 0, 1'b0);
        aa = {32{8'hAA}};
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 15'd7;
        req_wdata = aa;
        req_mask  = '1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_req_ready", VEC_W'(req_ready), VEC_W'(1));
        checkOutput("midrst_resp_valid", VEC_W'(resp_valid), VEC_W'(0));
        checkOutput("midrst_resp_err", VEC_W'(resp_err), VEC_W'(0));
        checkOutput("midrst_resp_rdata", resp_rdata, '0);
        @(negedge clk);
        rst = 1'b0;
        model[7][127:0] = aa[127:0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_response", VEC_W'(resp_valid), VEC_W'(0));
        end
        runTransaction(1'b0, 15'd7, '0, '0, 0, 1'b0);
        checkOutput("midrst_partial_pattern", model[7], {{16{8'h00}}, {16{8'hAA}}});

        // Random soak including out-of-range addresses and random back-pressure
        for (int t = 0; t < 2000; t++) begin
            if ($urandom_range(0, 7) == 0) a = ADDR_W'($urandom_range(1024, 32767));
            else a = ADDR_W'($urandom_range(0, 1023));
            runTransaction(1'($urandom_range(0, 1)), a, randVec(), LANES'($urandom),
                           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
